// File: rtl/asg_pkg.sv
// Shared definitions for the arbitrary-signal-generator interpolating channel:
// FSM state encoding, trigger-source codes and the interpolation weight width.
package asg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DELAY = 2'd2
    } asg_state_e;

    localparam logic [2:0] TRIG_NONE      = 3'd0;
    localparam logic [2:0] TRIG_SW        = 3'd1;
    localparam logic [2:0] TRIG_EXT_RISE  = 3'd2;
    localparam logic [2:0] TRIG_EXT_FALL  = 3'd3;
    localparam logic [2:0] TRIG_EXT_LEVEL = 3'd4;
    localparam logic [2:0] TRIG_ALWAYS    = 3'd5;

    // Number of fractional pointer bits used as the linear-interpolation weight.
    localparam int INTERP_W = 8;

endpackage

// File: rtl/asg_buf_2r1w.sv
// Sample buffer: one write port, two synchronous read ports.
// A read of the address being written in the same cycle returns the old word.
// Only the read registers are reset; memory contents survive reset.
module asg_buf_2r1w #(
    parameter int DW  = 14,
    parameter int RSZ = 14
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [RSZ-1:0]        waddr,
    input  logic signed [DW-1:0]  wdata,
    input  logic [RSZ-1:0]        raddr_a,
    input  logic [RSZ-1:0]        raddr_b,
    output logic signed [DW-1:0]  rdata_a,
    output logic signed [DW-1:0]  rdata_b
);

    logic signed [DW-1:0] mem [0:(1<<RSZ)-1];

    // Write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered reads; nonblocking update of mem gives read-old-data
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_a <= '0;
            rdata_b <= '0;
        end else begin
            rdata_a <= mem[raddr_a];
            rdata_b <= mem[raddr_b];
        end
    end

endmodule

// File: rtl/asg_interp_ch.sv
// One ASG output channel: trigger qualification, burst/repeat pointer FSM,
// sample buffer and a 5-stage scaling pipeline from pointer to dac_o.
// Optional linear interpolation between neighbouring samples is enabled
// with the macro ASG_INTERP_CH_LININTERP_EN; default build is nearest-lower.
module asg_interp_ch
    import asg_pkg::*;
#(
    parameter int DW         = 14,
    parameter int RSZ        = 14,
    parameter int FW         = 16,
    parameter int CYCLE_BITS = 32
) (
    input  logic                   dac_clk_i,
    input  logic                   dac_rst_i,
    input  logic                   trig_sw_i,
    input  logic                   trig_ext_i,
    input  logic [2:0]             trig_src_i,
    input  logic                   buf_we_i,
    input  logic [RSZ-1:0]         buf_addr_i,
    input  logic signed [DW-1:0]   buf_wdata_i,
    input  logic [RSZ+FW-1:0]      set_size_i,
    input  logic [RSZ+FW-1:0]      set_step_i,
    input  logic [RSZ+FW-1:0]      set_ofs_i,
    input  logic                   set_wrap_i,
    input  logic                   set_zero_i,
    input  logic                   set_rst_i,
    input  logic [DW-1:0]          set_amp_i,
    input  logic signed [DW-1:0]   set_dc_i,
    input  logic [CYCLE_BITS-1:0]  set_ncyc_i,
    input  logic [15:0]            set_nrep_i,
    input  logic [31:0]            set_rdly_i,
    output logic signed [DW-1:0]   dac_o,
    output logic [RSZ-1:0]         buf_rpnt_o,
    output logic                   busy_o,
    output logic                   trig_done_o
);

    localparam int PW = RSZ + FW;

    function automatic logic signed [DW+1:0] shift_add(input logic signed [2*DW:0] p,
                                                       input logic signed [DW-1:0] dc);
        return (DW+2)'(p >>> (DW-1)) + (DW+2)'(dc);
    endfunction

    function automatic logic signed [DW-1:0] sat(input logic signed [DW+1:0] v);
        if (v[DW+1:DW-1] == {3{v[DW+1]}})
            return v[DW-1:0];
        else if (v[DW+1])
            return {1'b1, {(DW-1){1'b0}}};
        else
            return {1'b0, {(DW-1){1'b1}}};
    endfunction

`ifdef ASG_INTERP_CH_LININTERP_EN
    function automatic logic signed [DW-1:0] lerp(input logic signed [DW-1:0] a,
                                                  input logic signed [DW-1:0] b,
                                                  input logic [INTERP_W-1:0] f);
        logic signed [DW:0]            d;
        logic signed [DW+INTERP_W+1:0] m;
        d = (DW+1)'(b) - (DW+1)'(a);
        m = (DW+INTERP_W+2)'(d) * (DW+INTERP_W+2)'($signed({1'b0, f}));
        return DW'((DW+INTERP_W+2)'(a) + (m >>> INTERP_W));
    endfunction
`endif

    asg_state_e             state;
    logic [PW-1:0]          pnt;
    logic [CYCLE_BITS-1:0]  cyc;
    logic [15:0]            rep;
    logic [31:0]            dly;
    logic                   trig_done;
    logic                   ext_d;
    logic                   trig;
    logic [PW:0]            npnt;
    logic                   wrap;
    logic [PW-1:0]          wrap_pnt;
    logic [15:0]            nrep_eff;
    logic [RSZ-1:0]         addr_a;
    logic [RSZ-1:0]         addr_b;
    logic signed [DW-1:0]   rd_a;
    logic signed [DW-1:0]   rd_b;

    logic [RSZ-1:0]         rpnt_p0;
    logic signed [DW-1:0]   s_p1;
    logic signed [2*DW:0]   prod_p2;
    logic signed [DW+1:0]   sum_p3;
    logic signed [DW-1:0]   dac_p4;
`ifdef ASG_INTERP_CH_LININTERP_EN
    logic [INTERP_W-1:0]    f_p0;
`endif

    assign npnt     = {1'b0, pnt} + {1'b0, set_step_i};
    assign wrap     = (state == ST_RUN) && (npnt > {1'b0, set_size_i});
    assign wrap_pnt = set_wrap_i ? (npnt[PW-1:0] - set_size_i - PW'(1)) : set_ofs_i;
    assign nrep_eff = (set_nrep_i == 16'd0) ? 16'd1 : set_nrep_i;
    assign addr_a   = pnt[PW-1:FW];

`ifdef ASG_INTERP_CH_LININTERP_EN
    assign addr_b = (addr_a == set_size_i[PW-1:FW]) ? set_ofs_i[PW-1:FW] : addr_a + RSZ'(1);
`else
    logic unused_rd_b;
    assign addr_b      = addr_a;
    assign unused_rd_b = ^rd_b;
`endif

    // Trigger qualification against the selected source
    always_comb begin
        case (trig_src_i)
            TRIG_NONE:      trig = 1'b0;
            TRIG_SW:        trig = trig_sw_i;
            TRIG_EXT_RISE:  trig = trig_ext_i & ~ext_d;
            TRIG_EXT_FALL:  trig = ~trig_ext_i & ext_d;
            TRIG_EXT_LEVEL: trig = trig_ext_i;
            TRIG_ALWAYS:    trig = 1'b1;
            default:        trig = 1'b0;
        endcase
    end

    // One-cycle delayed external trigger for edge detection
    always_ff @(posedge dac_clk_i) begin
        if (dac_rst_i) ext_d <= 1'b0;
        else           ext_d <= trig_ext_i;
    end

    // Burst / repeat FSM and read pointer; set_rst_i overrides trigger and wrap
    always_ff @(posedge dac_clk_i) begin
        if (dac_rst_i) begin
            state     <= ST_IDLE;
            pnt       <= '0;
            cyc       <= '0;
            rep       <= '0;
            dly       <= '0;
            trig_done <= 1'b0;
        end else if (set_rst_i) begin
            state     <= ST_IDLE;
            pnt       <= set_ofs_i;
            cyc       <= '0;
            rep       <= '0;
            dly       <= '0;
            trig_done <= 1'b0;
        end else begin
            trig_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (trig) begin
                        state     <= ST_RUN;
                        pnt       <= set_ofs_i;
                        cyc       <= set_ncyc_i;
                        rep       <= nrep_eff;
                        trig_done <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (wrap) begin
                        trig_done <= 1'b1;
                        if (cyc == CYCLE_BITS'(1)) begin
                            if (rep > 16'd1) begin
                                rep <= rep - 16'd1;
                                if (set_rdly_i == 32'd0) begin
                                    pnt <= set_ofs_i;
                                    cyc <= set_ncyc_i;
                                end else begin
                                    state <= ST_DELAY;
                                    dly   <= set_rdly_i;
                                    pnt   <= wrap_pnt;
                                end
                            end else begin
                                state <= ST_IDLE;
                                pnt   <= wrap_pnt;
                                cyc   <= '0;
                                rep   <= '0;
                            end
                        end else begin
                            pnt <= wrap_pnt;
                            if (cyc != '0) cyc <= cyc - CYCLE_BITS'(1);
                        end
                    end else begin
                        pnt <= npnt[PW-1:0];
                    end
                end
                ST_DELAY: begin
                    if (dly <= 32'd1) begin
                        state     <= ST_RUN;
                        pnt       <= set_ofs_i;
                        cyc       <= set_ncyc_i;
                        dly       <= '0;
                        trig_done <= 1'b1;
                    end else begin
                        dly <= dly - 32'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    asg_buf_2r1w #(
        .DW  (DW),
        .RSZ (RSZ)
    ) u_buf (
        .clk     (dac_clk_i),
        .rst     (dac_rst_i),
        .we      (buf_we_i),
        .waddr   (buf_addr_i),
        .wdata   (buf_wdata_i),
        .raddr_a (addr_a),
        .raddr_b (addr_b),
        .rdata_a (rd_a),
        .rdata_b (rd_b)
    );

    // Output pipeline: p0 read, p1 interpolate, p2 multiply, p3 shift+dc, p4 saturate
    always_ff @(posedge dac_clk_i) begin
        if (dac_rst_i) begin
            rpnt_p0 <= '0;
`ifdef ASG_INTERP_CH_LININTERP_EN
            f_p0    <= '0;
`endif
            s_p1    <= '0;
            prod_p2 <= '0;
            sum_p3  <= '0;
            dac_p4  <= '0;
        end else begin
            rpnt_p0 <= addr_a;
`ifdef ASG_INTERP_CH_LININTERP_EN
            f_p0    <= pnt[FW-1 -: INTERP_W];
            s_p1    <= lerp(rd_a, rd_b, f_p0);
`else
            s_p1    <= rd_a;
`endif
            prod_p2 <= (2*DW+1)'(s_p1) * (2*DW+1)'($signed({1'b0, set_amp_i}));
            sum_p3  <= shift_add(prod_p2, set_dc_i);
            dac_p4  <= set_zero_i ? '0 : sat(sum_p3);
        end
    end

    assign dac_o       = dac_p4;
    assign buf_rpnt_o  = rpnt_p0;
    assign busy_o      = (state == ST_RUN) || (state == ST_DELAY);
    assign trig_done_o = trig_done;

endmodule

// File: doc/asg_interp_ch.md
ASG_INTERP_CH -- requirements
Module: asg_interp_ch

Interface
REQ-001 The block SHALL have parameter DW, default 14, meaning sample and DAC width.
REQ-002 The block SHALL have parameter RSZ, default 14, meaning log2 of buffer depth.
REQ-003 The block SHALL have parameter FW, default 16, meaning pointer fraction bits.
REQ-004 The block SHALL have parameter CYCLE_BITS, default 32, meaning cycle counter width.
REQ-005 The block SHALL have port dac_clk_i, in, 1, the single clock; all logic on its rising edge.
REQ-006 The block SHALL have port dac_rst_i, in, 1, reset, synchronous and active-high.
REQ-007 The block SHALL have trigger ports: trig_sw_i in 1; trig_ext_i in 1 (pre-synchronised); trig_src_i in 3 (0 none, 1 sw, 2 ext rising, 3 ext falling, 4 ext level, 5 always).
REQ-008 The block SHALL have buffer write ports buf_we_i in 1, buf_addr_i in RSZ, and buf_wdata_i in DW signed.
REQ-009 The block SHALL have set_size_i, set_step_i and set_ofs_i, each in RSZ+FW, unsigned fixed point: last pointer, step and start.
REQ-010 The block SHALL have set_wrap_i in 1, set_zero_i in 1 and set_rst_i in 1.
REQ-011 The block SHALL have set_amp_i in DW (unsigned, 1.0 = 2^(DW-1)) and set_dc_i in DW (signed).
REQ-012 The block SHALL have set_ncyc_i in CYCLE_BITS, set_nrep_i in 16, and set_rdly_i in 32 (delay in clock cycles).
REQ-013 The block SHALL have outputs dac_o out DW signed, buf_rpnt_o out RSZ, busy_o out 1, and trig_done_o out 1.

Function
REQ-014 The FSM SHALL have states IDLE, RUN and DELAY; busy_o SHALL be 1 in RUN and DELAY.
REQ-015 In IDLE, a qualified trigger SHALL cause the following on the next edge: move to RUN, load pnt=set_ofs_i, cyc=set_ncyc_i, rep=set_nrep_i.
REQ-016 Triggers arriving in RUN or DELAY SHALL be ignored.
REQ-017 In RUN, the block SHALL compute npnt=pnt+set_step_i in RSZ+FW+1 bits; when npnt>set_size_i, a wrap occurs.
REQ-018 On wrap, the pointer SHALL become npnt-set_size_i-1 if set_wrap_i=1, else set_ofs_i; otherwise the pointer SHALL become npnt.
REQ-019 Each wrap SHALL decrement cyc; ncyc=0 SHALL mean infinite cycles.
REQ-020 A wrap with cyc=1 SHALL end the burst: if rep>1, go to DELAY with dly=set_rdly_i and rep decremented; else go to IDLE.
REQ-021 If set_rdly_i=0 at burst end with rep>1, the FSM SHALL go directly to RUN, reload pnt and cyc, and decrement rep.
REQ-022 DELAY SHALL decrement dly each cycle; at dly=1 it SHALL return to RUN, reloading pnt=set_ofs_i and cyc=set_ncyc_i.
REQ-023 set_nrep_i=0 SHALL be treated as 1.
REQ-024 set_rst_i SHALL have highest priority: it forces IDLE and pnt=set_ofs_i, and overrides a simultaneous trigger or wrap.
REQ-025 trig_done_o SHALL pulse for one cycle on every wrap and on burst start.
REQ-026 Edge triggers SHALL be detected from a one-cycle-delayed trig_ext_i.
REQ-027 buf_rpnt_o SHALL equal pnt[RSZ+FW-1:FW], registered.
REQ-028 dac_o SHALL lag pointer update by exactly 5 cycles in every configuration.
REQ-029 Scaling SHALL be sample*amp, arithmetic shift right DW-1, plus dc, then saturated to DW signed range.
REQ-030 In IDLE, dac_o SHALL hold the last sample scaled output of pnt.
REQ-031 set_zero_i SHALL force dac_o to 0 at the output register.
REQ-032 A buffer write to the address being read SHALL return the old data to the reader.

Reset
REQ-033 On dac_rst_i, the block SHALL set state=IDLE, pnt=0, cyc=0, rep=0, dly=0, dac_o=0, buf_rpnt_o=0, busy_o=0, trig_done_o=0, and clear the pipeline; buffer contents SHALL be preserved.
REQ-034 Reset mid-RUN SHALL abort the burst within one cycle; the next trigger SHALL start a fresh burst.

Configuration
REQ-035 With macro ASG_INTERP_CH_LININTERP_EN defined, the output SHALL be a+(((b-a)*f)>>>8), where a=buf[i], b=buf[i+1], and f=pnt[FW-1:FW-8].
REQ-036 Under ASG_INTERP_CH_LININTERP_EN, i+1 SHALL wrap to set_ofs_i integer part when i equals the set_size_i integer part.
REQ-037 Without ASG_INTERP_CH_LININTERP_EN, output SHALL be nearest-lower sample a only, with pipeline padding keeping latency at 5.

Structure
REQ-038 Package asg_pkg SHALL hold the FSM state enum, trigger-source encodings, and the interpolation weight width constant (8).
REQ-039 Sub-module asg_buf_2r1w SHALL implement the RAM: one write port and two synchronous read ports, with read-old-data behaviour.

Verification
REQ-040 The bench SHALL check: buf[k]=k*100, size=(7<<16)|0xFFFF, step=1<<16, ncyc=2, sw trigger -> buf_rpnt_o 0..7,0..7, then IDLE; trig_done_o pulses 3 times.
REQ-041 The bench SHALL check: nrep=3, rdly=10, ncyc=1 -> 3 bursts, each separated by 10 cycles busy with no pointer motion; busy_o drops after the third.
REQ-042 The bench SHALL check, with interp: buf[0]=0, buf[1]=1000, step=0x4000, amp=8192, dc=0 -> dac_o sequence 0, 250, 500, 750, 1000.
REQ-043 The bench SHALL check: amp=8191, dc=8191, sample=8191 -> dac_o=8191 saturated; sample=-8192, dc=-8192 -> -8192.
REQ-044 The bench SHALL check: set_rst_i asserted in the same cycle as a wrap in RUN -> IDLE, pnt=set_ofs_i, no trig_done_o pulse.
REQ-045 The bench SHALL check: dac_rst_i mid-DELAY -> all outputs 0 next cycle; a rising ext trigger then restarts at set_ofs_i.
